// File: rtl/vga_timing_gen_p_if.sv
// Pixel/config/video bundle for vga_timing_gen_p.
// The slave side is the timing generator; the master side is the pixel source and display sink.
interface vga_timing_gen_p_if #(
  parameter int CW = 13,
  parameter int DW = 8
);
  logic [DW-1:0] iRed;
  logic [DW-1:0] iGreen;
  logic [DW-1:0] iBlue;
  logic          iGray;
  logic [15:0]   iVideo_W;
  logic [15:0]   iVideo_H;
  logic [15:0]   iX_OFF;
  logic [15:0]   iY_OFF;
`ifdef VGA_TESTPAT_EN
  logic          iTestPat;
`endif
  logic          oRequest;
  logic          oFrameStart;
  logic          oFrameDone;
  logic [DW-1:0] oVGA_R;
  logic [DW-1:0] oVGA_G;
  logic [DW-1:0] oVGA_B;
  logic          oVGA_H_SYNC;
  logic          oVGA_V_SYNC;
  logic          oVGA_BLANK;
  logic          oVGA_SYNC;
  logic [CW-1:0] H_Cont;
  logic [CW-1:0] V_Cont;

  modport slave (
    input  iRed, iGreen, iBlue, iGray, iVideo_W, iVideo_H, iX_OFF, iY_OFF,
`ifdef VGA_TESTPAT_EN
    input  iTestPat,
`endif
    output oRequest, oFrameStart, oFrameDone, oVGA_R, oVGA_G, oVGA_B,
    output oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC, H_Cont, V_Cont
  );

  modport master (
    output iRed, iGreen, iBlue, iGray, iVideo_W, iVideo_H, iX_OFF, iY_OFF,
`ifdef VGA_TESTPAT_EN
    output iTestPat,
`endif
    input  oRequest, oFrameStart, oFrameDone, oVGA_R, oVGA_G, oVGA_B,
    input  oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC, H_Cont, V_Cont
  );
endinterface

// File: rtl/vga_timing_gen_p.sv
// VGA/DVI raster timing with a per-frame shadowed pixel window and a two-stage output pipeline.
// Build macro VGA_TESTPAT_EN adds iTestPat and an internal 8-bar colour pattern.
module vga_timing_gen_p #(
  parameter int CW     = 13,
  parameter int DW     = 8,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0
) (
  input logic               iCLK,
  input logic               iRST,
  vga_timing_gen_p_if.slave vif
);
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int AW    = 18;
  localparam int SW    = DW + 2;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
  localparam logic [AW-1:0] X0         = AW'(H_SYNC + H_BP);
  localparam logic [AW-1:0] X_END      = AW'(H_SYNC + H_BP + H_ACT);
  localparam logic [AW-1:0] Y0         = AW'(V_SYNC + V_BP);
  localparam logic [AW-1:0] Y_END      = AW'(V_SYNC + V_BP + V_ACT);
  localparam logic          HS_ON      = 1'(HS_POL);
  localparam logic          VS_ON      = 1'(VS_POL);

  logic [CW-1:0] r_h_cont, r_v_cont;
  logic [15:0]   r_w, r_h, r_xo, r_yo;
  logic          r1_hs, r1_vs, r1_de, r1_req, r_done;
  logic          r_hs_pin, r_vs_pin, r_blank;
  logic [DW-1:0] r_red, r_green, r_blue;

  logic          w_frame_top;
  logic [AW-1:0] w_h_ext, w_v_ext;
  logic [AW-1:0] w_xs, w_xe, w_xclip, w_ys, w_ye, w_yclip;
  logic          w_in_win, w_last, w_req, w_de;
  logic [SW-1:0] w_sum;
  logic [DW-1:0] w_gray;
  logic [DW-1:0] w_red, w_green, w_blue;

  assign w_frame_top = (r_h_cont == '0) && (r_v_cont == '0);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_h_cont <= '0;
      r_v_cont <= '0;
    end else if (r_h_cont == H_LAST) begin
      r_h_cont <= '0;
      r_v_cont <= (r_v_cont == V_LAST) ? '0 : r_v_cont + 1'b1;
    end else begin
      r_h_cont <= r_h_cont + 1'b1;
    end
  end

  // Geometry is only sampled at the top of the frame so the window never tears.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_w  <= '0;
      r_h  <= '0;
      r_xo <= '0;
      r_yo <= '0;
    end else if (w_frame_top) begin
      r_w  <= vif.iVideo_W;
      r_h  <= vif.iVideo_H;
      r_xo <= vif.iX_OFF;
      r_yo <= vif.iY_OFF;
    end
  end

  assign w_h_ext = AW'(r_h_cont);
  assign w_v_ext = AW'(r_v_cont);
  assign w_xs    = X0 + AW'(r_xo);
  assign w_xe    = w_xs + AW'(r_w);
  assign w_xclip = (w_xe < X_END) ? w_xe : X_END;
  assign w_ys    = Y0 + AW'(r_yo);
  assign w_ye    = w_ys + AW'(r_h);
  assign w_yclip = (w_ye < Y_END) ? w_ye : Y_END;

  // Window start is never left of the active start, and the clipped end never right of it.
  assign w_in_win = (w_h_ext >= w_xs) && (w_h_ext < w_xclip) &&
                    (w_v_ext >= w_ys) && (w_v_ext < w_yclip);
  assign w_last   = (w_h_ext + AW'(1) == w_xclip) && (w_v_ext + AW'(1) == w_yclip);
  assign w_de     = (w_h_ext >= X0) && (w_h_ext < X_END) &&
                    (w_v_ext >= Y0) && (w_v_ext < Y_END);

`ifdef VGA_TESTPAT_EN
  localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
  logic       r1_tp;
  logic [2:0] r1_bar;

  assign w_req = w_in_win & ~iRST & ~vif.iTestPat;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r1_tp  <= 1'b0;
      r1_bar <= '0;
    end else begin
      r1_tp  <= vif.iTestPat;
      r1_bar <= 3'((w_h_ext - X0) / AW'(BAR_W));
    end
  end
`else
  assign w_req = w_in_win & ~iRST;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r1_hs  <= 1'b0;
      r1_vs  <= 1'b0;
      r1_de  <= 1'b0;
      r1_req <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r1_hs  <= (r_h_cont < H_SYNC_END);
      r1_vs  <= (r_v_cont < V_SYNC_END);
      r1_de  <= w_de;
      r1_req <= w_req;
      r_done <= w_req & w_last;
    end
  end

  assign w_sum  = SW'(vif.iRed) + SW'(vif.iGreen) + SW'(vif.iBlue);
  assign w_gray = DW'(w_sum / SW'(3));

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    if (r1_req) begin
      if (vif.iGray) begin
        w_red   = w_gray;
        w_green = w_gray;
        w_blue  = w_gray;
      end else begin
        w_red   = vif.iRed;
        w_green = vif.iGreen;
        w_blue  = vif.iBlue;
      end
    end
`ifdef VGA_TESTPAT_EN
    if (r1_tp && r1_de) begin
      w_red   = {DW{r1_bar[2]}};
      w_green = {DW{r1_bar[1]}};
      w_blue  = {DW{r1_bar[0]}};
    end
`endif
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_hs_pin <= ~HS_ON;
      r_vs_pin <= ~VS_ON;
      r_blank  <= 1'b0;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
    end else begin
      r_hs_pin <= r1_hs ? HS_ON : ~HS_ON;
      r_vs_pin <= r1_vs ? VS_ON : ~VS_ON;
      r_blank  <= r1_de;
      r_red    <= w_red;
      r_green  <= w_green;
      r_blue   <= w_blue;
    end
  end

  assign vif.oRequest    = w_req;
  assign vif.oFrameStart = w_frame_top & ~iRST;
  assign vif.oFrameDone  = r_done;
  assign vif.oVGA_R      = r_red;
  assign vif.oVGA_G      = r_green;
  assign vif.oVGA_B      = r_blue;
  assign vif.oVGA_H_SYNC = r_hs_pin;
  assign vif.oVGA_V_SYNC = r_vs_pin;
  assign vif.oVGA_BLANK  = r_blank;
  assign vif.oVGA_SYNC   = 1'b0;
  assign vif.H_Cont      = r_h_cont;
  assign vif.V_Cont      = r_v_cont;
endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Directed bench for vga_timing_gen_p on a reduced 23 x 17 raster (active 16 x 12 at x=5, y=4).
module tb_vga_timing_gen_p;
  localparam int CW = 13, DW = 8;
  localparam int H_ACT = 16, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_ACT = 12, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int HT = 23, VT = 17, FRAME = HT * VT;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  vga_timing_gen_p_if #(.CW(CW), .DW(DW)) vif();

  vga_timing_gen_p #(
    .CW(CW), .DW(DW),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(0), .VS_POL(0)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .vif (vif)
  );

  always #5 iCLK = ~iCLK;

  // Window config plus hand-computed request rectangle (inclusive corners) and first output pixel.
  typedef struct {
    logic [15:0] w, h, xo, yo;
    logic        gray, fixed;
    int          fx, fy, lx, ly, cnt;
    logic [7:0]  er, eg, eb;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int c, input logic fixed);
    if (fixed) return {8'd255, 8'd255, 8'd254};
    return {8'(c * 7 + 3), 8'(c * 13), 8'(c * 5 + 1)};
  endfunction

  function automatic logic in_rect(input vec_t t, input int c);
    int h, v;
    h = c % HT;
    v = c / HT;
    return (t.cnt > 0) && (h >= t.fx) && (h <= t.lx) && (v >= t.fy) && (v <= t.ly);
  endfunction

  task automatic set_cfg(input vec_t t);
    vif.iVideo_W = t.w;
    vif.iVideo_H = t.h;
    vif.iX_OFF   = t.xo;
    vif.iY_OFF   = t.yo;
    vif.iGray    = t.gray;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hcont"}, vif.H_Cont, 0);
    chk({tag, "_vcont"}, vif.V_Cont, 0);
    chk({tag, "_sync_blank"}, {vif.oVGA_H_SYNC, vif.oVGA_V_SYNC, vif.oVGA_BLANK, vif.oVGA_SYNC}, 4'b1100);
    chk({tag, "_rgb"}, {vif.oVGA_R, vif.oVGA_G, vif.oVGA_B}, 0);
    chk({tag, "_pulses"}, {vif.oRequest, vif.oFrameStart, vif.oFrameDone}, 0);
  endtask

  // Leaves the bench 1 time unit after the edge that starts the first post-reset cycle.
  task automatic do_reset();
    @(posedge iCLK); #1;
    iRST = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    check_reset("rst");
    @(posedge iCLK);
    @(posedge iCLK); #1;
    iRST = 1'b0;
  endtask

  task automatic run_frame(input string tag, input vec_t t, input int ncyc, input int chg_c, input logic [15:0] chg_w);
    int e_h, e_v, e_fs, e_req, e_done, e_hs, e_vs, e_bl, e_rgb;
    int n_req, n_done, first_c, done_c, h2, v2, avg;
    logic req_e, done_e, hs_e, vs_e, bl_e;
    logic [23:0] p, q, rgb_e;
    e_h = 0; e_v = 0; e_fs = 0; e_req = 0; e_done = 0; e_hs = 0; e_vs = 0; e_bl = 0; e_rgb = 0;
    n_req = 0; n_done = 0; first_c = -1; done_c = -1;
    for (int c = 0; c < ncyc; c++) begin
      p = pix(c, t.fixed);
      vif.iRed   = p[23:16];
      vif.iGreen = p[15:8];
      vif.iBlue  = p[7:0];
      if (c == chg_c) vif.iVideo_W = chg_w;
      @(negedge iCLK);
      if (vif.H_Cont !== CW'(c % HT)) e_h++;
      if (vif.V_Cont !== CW'(c / HT)) e_v++;
      if (vif.oFrameStart !== (c == 0)) e_fs++;
      req_e = in_rect(t, c);
      if (vif.oRequest !== req_e) e_req++;
      if (vif.oRequest === 1'b1) begin
        n_req++;
        if (first_c < 0) first_c = c;
      end
      done_e = (t.cnt > 0) && (c == t.ly * HT + t.lx + 1);
      if (vif.oFrameDone !== done_e) e_done++;
      if (vif.oFrameDone === 1'b1) begin
        n_done++;
        done_c = c;
      end
      hs_e = 1'b1; vs_e = 1'b1; bl_e = 1'b0; rgb_e = '0;
      if (c >= 2) begin
        h2 = (c - 2) % HT;
        v2 = (c - 2) / HT;
        hs_e = !(h2 < H_SYNC);
        vs_e = !(v2 < V_SYNC);
        bl_e = (h2 >= 5) && (h2 < 21) && (v2 >= 4) && (v2 < 16);
        if (in_rect(t, c - 2)) begin
          q = pix(c - 1, t.fixed);
          avg = (int'(q[23:16]) + int'(q[15:8]) + int'(q[7:0])) / 3;
          rgb_e = t.gray ? {3{8'(avg)}} : q;
        end
      end
      if (vif.oVGA_H_SYNC !== hs_e) e_hs++;
      if (vif.oVGA_V_SYNC !== vs_e) e_vs++;
      if (vif.oVGA_BLANK !== bl_e) e_bl++;
      if ({vif.oVGA_R, vif.oVGA_G, vif.oVGA_B} !== rgb_e) e_rgb++;
      if (t.fixed && t.cnt > 0 && c == t.fy * HT + t.fx + 2)
        chk({tag, "_first_pixel"}, {vif.oVGA_R, vif.oVGA_G, vif.oVGA_B}, {t.er, t.eg, t.eb});
      @(posedge iCLK); #1;
    end
    chk({tag, "_hcont_mism"}, e_h, 0);
    chk({tag, "_vcont_mism"}, e_v, 0);
    chk({tag, "_fstart_mism"}, e_fs, 0);
    chk({tag, "_req_mism"}, e_req, 0);
    chk({tag, "_done_mism"}, e_done, 0);
    chk({tag, "_hsync_mism"}, e_hs, 0);
    chk({tag, "_vsync_mism"}, e_vs, 0);
    chk({tag, "_blank_mism"}, e_bl, 0);
    chk({tag, "_rgb_mism"}, e_rgb, 0);
    if (ncyc == FRAME) begin
      chk({tag, "_req_count"}, n_req, t.cnt);
      chk({tag, "_first_req"}, first_c, (t.cnt > 0) ? t.fy * HT + t.fx : -1);
      chk({tag, "_done_count"}, n_done, (t.cnt > 0) ? 1 : 0);
      chk({tag, "_done_pos"}, done_c, (t.cnt > 0) ? t.ly * HT + t.lx + 1 : -1);
    end
  endtask

  vec_t vecs[6];
  vec_t v_narrow, v_wide;

  initial begin
    //          w    h    xo   yo  gray fixed fx  fy  lx  ly  cnt  er    eg    eb
    vecs[0] = '{16'd4,   16'd3,  16'd2,  16'd1,  1'b0, 1'b0, 7,  5,  10, 7,  12,  8'd0,   8'd0,   8'd0};
    vecs[1] = '{16'd8,   16'd4,  16'd12, 16'd10, 1'b1, 1'b0, 17, 14, 20, 15, 8,   8'd0,   8'd0,   8'd0};
    vecs[2] = '{16'd0,   16'd5,  16'd3,  16'd2,  1'b0, 1'b0, 1,  1,  0,  0,  0,   8'd0,   8'd0,   8'd0};
    vecs[3] = '{16'd4,   16'd4,  16'd16, 16'd0,  1'b0, 1'b0, 1,  1,  0,  0,  0,   8'd0,   8'd0,   8'd0};
    vecs[4] = '{16'd16,  16'd12, 16'd0,  16'd0,  1'b1, 1'b1, 5,  4,  20, 15, 192, 8'd254, 8'd254, 8'd254};
    vecs[5] = '{16'd100, 16'd1,  16'd14, 16'd11, 1'b0, 1'b1, 19, 15, 20, 15, 2,   8'd255, 8'd255, 8'd254};
    v_narrow = vecs[0];
    v_wide   = '{16'd8, 16'd3, 16'd2, 16'd1, 1'b0, 1'b0, 7, 5, 14, 7, 24, 8'd0, 8'd0, 8'd0};

    vif.iRed = '0; vif.iGreen = '0; vif.iBlue = '0;
    set_cfg(vecs[0]);

    for (int i = 0; i < 6; i++) begin
      set_cfg(vecs[i]);
      do_reset();
      run_frame($sformatf("vec%0d", i), vecs[i], FRAME, -1, 16'd0);
    end

    // Width change early in a frame must wait for the next frame top.
    set_cfg(v_narrow);
    do_reset();
    run_frame("wchg_f1", v_narrow, FRAME, 50, 16'd8);
    run_frame("wchg_f2", v_wide, FRAME, -1, 16'd0);
    @(negedge iCLK);
    chk("wrap_to_origin", {vif.H_Cont, vif.V_Cont, vif.oFrameStart}, {13'd0, 13'd0, 1'b1});

    // Reset in the middle of requests aborts the frame without a done pulse.
    set_cfg(vecs[4]);
    do_reset();
    run_frame("pre_abort", vecs[4], 8 * HT + 10, -1, 16'd0);
    iRST = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    check_reset("abort");
    @(posedge iCLK); #1;
    iRST = 1'b0;
    run_frame("post_abort", vecs[4], FRAME, -1, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
